// File: rtl/mc_port_arbiter_pkg.sv
// rtl/mc_port_arbiter_pkg.sv - shared MIG command codes and arbiter state encoding
package mc_arb_defs;

    localparam logic [2:0] MC_INSTR_WR = 3'b000;
    localparam logic [2:0] MC_INSTR_RD = 3'b001;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_CMD  = 3'd2,
        RD_CMD  = 3'd3,
        RD_WAIT = 3'd4,
        DONE    = 3'd5
    } arb_state_t;

    // Width of a requester index for 2..4 requesters.
    function automatic int idx_width(input int nreq);
        return (nreq > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/mc_port_arbiter_if.sv
// rtl/mc_port_arbiter_if.sv - requester bus and MIG user-port bundle with master/slave views
interface mc_port_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 31,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_done;
    logic [NREQ-1:0]        req_err;
    logic [DATA_W-1:0]      rsp_rdata;

    logic                   mc_cmd_en;
    logic [2:0]             mc_cmd_instr;
    logic [ADDR_W-1:0]      mc_cmd_addr;
    logic                   mc_cmd_full;
    logic                   mc_wr_en;
    logic [DATA_W-1:0]      mc_wr_data;
    logic                   mc_wr_full;
    logic                   mc_rd_en;
    logic [DATA_W-1:0]      mc_rd_data;
    logic                   mc_rd_empty;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_done, req_err, rsp_rdata,
        output mc_cmd_en, mc_cmd_instr, mc_cmd_addr,
        input  mc_cmd_full,
        output mc_wr_en, mc_wr_data,
        input  mc_wr_full,
        output mc_rd_en,
        input  mc_rd_data, mc_rd_empty
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_done, req_err, rsp_rdata,
        input  mc_cmd_en, mc_cmd_instr, mc_cmd_addr,
        output mc_cmd_full,
        input  mc_wr_en, mc_wr_data,
        output mc_wr_full,
        input  mc_rd_en,
        output mc_rd_data, mc_rd_empty
    );
endinterface

// File: rtl/mc_port_arbiter_rr_arbiter.sv
// rtl/mc_port_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any_valid
);
    int idx;

    // Scan from the farthest offset down so the nearest set bit at/after ptr wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                grant     = IDX_W'(idx);
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mc_port_arbiter.sv
// rtl/mc_port_arbiter.sv - round-robin sharing of one MIG user port; MC_RD_TIMEOUT_EN adds a read-wait abort
module mc_port_arbiter
    import mc_arb_defs::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_W     = 31,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    mc_port_arbiter_if.master   bus
);
    localparam int IDX_W = idx_width(NREQ);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  pick;
    logic              any_valid;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [NREQ-1:0]   done_vec;
    logic              rd_pop;
    logic              rd_timeout;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (pick),
        .any_valid (any_valid)
    );

    assign rd_pop = (state == RD_WAIT) && !bus.mc_rd_empty;

`ifdef MC_RD_TIMEOUT_EN
    localparam int TO_W = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state != RD_WAIT) begin
            to_cnt <= '0;
        end else if (bus.mc_rd_empty) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires on the last of RD_TIMEOUT consecutive empty cycles in RD_WAIT.
    assign rd_timeout = (state == RD_WAIT) && bus.mc_rd_empty &&
                        (to_cnt >= TO_W'(RD_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE) begin
            err_q <= 1'b0;
        end else if (state == RD_WAIT) begin
            err_q <= rd_timeout;
        end
    end

    assign bus.req_err = err_q ? done_vec : '0;
`else
    assign rd_timeout  = (RD_TIMEOUT < 0);
    assign bus.req_err = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = bus.req_we[pick] ? WR_DATA : RD_CMD;
                end
            end
            WR_DATA: if (!bus.mc_wr_full)  state_nxt = WR_CMD;
            WR_CMD:  if (!bus.mc_cmd_full) state_nxt = DONE;
            RD_CMD:  if (!bus.mc_cmd_full) state_nxt = RD_WAIT;
            RD_WAIT: if (rd_pop || rd_timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rr_ptr  <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && any_valid) begin
                grant_q <= pick;
                addr_q  <= bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
                wdata_q <= bus.req_wdata[int'(pick)*DATA_W +: DATA_W];
            end
            if (state == DONE) begin
                rr_ptr <= (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            end
            if (rd_pop) begin
                rdata_q <= bus.mc_rd_data;
            end else if (rd_timeout) begin
                rdata_q <= '0;
            end
        end
    end

    assign done_vec = (state == DONE) ? (NREQ'(1) << grant_q) : '0;

    assign bus.req_done     = done_vec;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.mc_cmd_en    = (state == WR_CMD || state == RD_CMD) && !bus.mc_cmd_full;
    assign bus.mc_cmd_instr = (state == RD_CMD) ? MC_INSTR_RD : MC_INSTR_WR;
    assign bus.mc_cmd_addr  = addr_q;
    assign bus.mc_wr_en     = (state == WR_DATA) && !bus.mc_wr_full;
    assign bus.mc_wr_data   = wdata_q;
    assign bus.mc_rd_en     = rd_pop;
endmodule

// File: tb/tb_mc_port_arbiter.sv
// tb/tb_mc_port_arbiter.sv - scoreboard bench for mc_port_arbiter
module tb_mc_port_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 31;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mc_port_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         kind;
        logic [2:0] instr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mig_op_t;

    typedef struct {
        int         idx;
        bit         is_rd;
        bit         err;
        logic [DW-1:0] rdata;
    } done_t;

    mig_op_t mig_q[$];
    done_t   done_q[$];
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic exp_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mig_q.push_back('{kind: 0, instr: 3'b000, addr: '0, data: d});
        mig_q.push_back('{kind: 1, instr: 3'b000, addr: a, data: '0});
        done_q.push_back('{idx: i, is_rd: 1'b0, err: 1'b0, rdata: '0});
    endtask

    task automatic exp_read(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit err, input bit with_done);
        mig_q.push_back('{kind: 1, instr: 3'b001, addr: a, data: '0});
        if (!err && with_done) mig_q.push_back('{kind: 2, instr: 3'b000, addr: '0, data: '0});
        if (with_done) done_q.push_back('{idx: i, is_rd: 1'b1, err: err, rdata: d});
    endtask

    task automatic wait_done(input int i, input int budget, inout int lat);
        int n;
        n = 0;
        do begin
            tick();
            lat++;
            n++;
        end while (!bus.req_done[i] && n < budget);
        if (!bus.req_done[i]) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_done_req%0d: no done within %0d cycles", i, budget);
        end
    endtask

    task automatic do_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int lat;
        lat = 0;
        exp_write(i, a, d);
        set_req(i, 1'b1, 1'b1, a, d);
        wait_done(i, 40, lat);
        set_req(i, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic mig_event(input int kind, input logic [2:0] instr,
                             input logic [AW-1:0] addr, input logic [DW-1:0] data);
        mig_op_t e;
        if (mig_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL mig_unexpected: kind %0d addr 0x%0h data 0x%0h", kind, addr, data);
        end else begin
            e = mig_q.pop_front();
            check("mig_kind", 64'(kind), 64'(e.kind));
            if (kind == 0) check("wr_data", 64'(data), 64'(e.data));
            if (kind == 1) begin
                check("cmd_instr", 64'(instr), 64'(e.instr));
                check("cmd_addr", 64'(addr), 64'(e.addr));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mc_wr_en) begin
                check("wr_en_while_full", 64'(bus.mc_wr_full), 64'd0);
                mig_event(0, 3'b000, '0, bus.mc_wr_data);
            end
            if (bus.mc_cmd_en) begin
                check("cmd_en_while_full", 64'(bus.mc_cmd_full), 64'd0);
                mig_event(1, bus.mc_cmd_instr, bus.mc_cmd_addr, '0);
            end
            if (bus.mc_rd_en) begin
                check("rd_en_while_empty", 64'(bus.mc_rd_empty), 64'd0);
                mig_event(2, 3'b000, '0, '0);
            end
            if (bus.req_done != '0) begin
                done_t e;
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL done_unexpected: req_done 0x%0h", bus.req_done);
                end else begin
                    e = done_q.pop_front();
                    check("done_grant", 64'(bus.req_done), 64'(NREQ'(1) << e.idx));
                    check("done_err", 64'(bus.req_err), e.err ? 64'(NREQ'(1) << e.idx) : 64'd0);
                    if (e.is_rd) check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [AW-1:0] rr_addr [2][2];
        int rr_cnt [2];
        int rr_done;
        int guard;

        bus.req_valid   = '0;
        bus.req_we      = '0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.mc_cmd_full = 1'b0;
        bus.mc_wr_full  = 1'b0;
        bus.mc_rd_data  = '0;
        bus.mc_rd_empty = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_req_done", 64'(bus.req_done), 64'd0);
        check("rst_req_err", 64'(bus.req_err), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst_cmd_en", 64'(bus.mc_cmd_en), 64'd0);
        check("rst_wr_en", 64'(bus.mc_wr_en), 64'd0);
        check("rst_rd_en", 64'(bus.mc_rd_en), 64'd0);
        rst = 1'b0;
        tick();

        // Unstalled write: push in cycle 2, command in cycle 3, done in cycle 4.
        exp_write(0, 31'h0001000, 32'hDEADBEEF);
        set_req(0, 1'b1, 1'b1, 31'h0001000, 32'hDEADBEEF);
        tick();
        check("t1_wr_en_cycle2", 64'(bus.mc_wr_en), 64'd1);
        tick();
        check("t1_cmd_en_cycle3", 64'(bus.mc_cmd_en), 64'd1);
        tick();
        check("t1_done_cycle4", 64'(bus.req_done), 64'd1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        tick();

        // Write with 5 cycles of wr_full then 3 cycles of cmd_full.
        exp_write(0, 31'h0001004, 32'hCAFEF00D);
        bus.mc_wr_full  = 1'b1;
        bus.mc_cmd_full = 1'b1;
        set_req(0, 1'b1, 1'b1, 31'h0001004, 32'hCAFEF00D);
        lat = 0;
        repeat (6) begin
            tick();
            lat++;
        end
        check("t2_wr_en_stalled", 64'(bus.mc_wr_en), 64'd0);
        bus.mc_wr_full = 1'b0;
        #1;
        check("t2_wr_en_first_free", 64'(bus.mc_wr_en), 64'd1);
        repeat (4) begin
            tick();
            lat++;
        end
        check("t2_cmd_en_stalled", 64'(bus.mc_cmd_en), 64'd0);
        bus.mc_cmd_full = 1'b0;
        #1;
        check("t2_cmd_en_first_free", 64'(bus.mc_cmd_en), 64'd1);
        wait_done(0, 20, lat);
        check("t2_latency", 64'(lat), 64'd11);
        set_req(0, 1'b0, 1'b0, '0, '0);
        tick();

        // Read by requester 1; FIFO goes non-empty 6 cycles after the command.
        exp_read(1, 31'h0001020, 32'h12345678, 1'b0, 1'b1);
        set_req(1, 1'b1, 1'b0, 31'h0001020, '0);
        tick();
        check("t3_rd_cmd_en", 64'(bus.mc_cmd_en), 64'd1);
        repeat (6) tick();
        bus.mc_rd_empty = 1'b0;
        bus.mc_rd_data  = 32'h12345678;
        lat = 0;
        wait_done(1, 20, lat);
        bus.mc_rd_empty = 1'b1;
        bus.mc_rd_data  = '0;
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Both requesters continuously valid: grants must alternate 0,1,0,1.
        rr_addr[0][0] = 31'h0001000;
        rr_addr[1][0] = 31'h0001008;
        rr_addr[0][1] = 31'h0001010;
        rr_addr[1][1] = 31'h0001018;
        for (int k = 0; k < 4; k++) begin
            exp_write(k % 2, rr_addr[k % 2][k / 2], 32'hA5000000 | 32'(rr_addr[k % 2][k / 2]));
        end
        rr_cnt[0] = 0;
        rr_cnt[1] = 0;
        rr_done   = 0;
        set_req(0, 1'b1, 1'b1, rr_addr[0][0], 32'hA5000000 | 32'(rr_addr[0][0]));
        set_req(1, 1'b1, 1'b1, rr_addr[1][0], 32'hA5000000 | 32'(rr_addr[1][0]));
        guard = 0;
        while (rr_done < 4 && guard < 100) begin
            tick();
            guard++;
            for (int r = 0; r < 2; r++) begin
                if (bus.req_done[r]) begin
                    rr_done++;
                    rr_cnt[r]++;
                    if (rr_cnt[r] < 2)
                        set_req(r, 1'b1, 1'b1, rr_addr[r][rr_cnt[r]],
                                32'hA5000000 | 32'(rr_addr[r][rr_cnt[r]]));
                    else
                        set_req(r, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        check("t4_rr_done_count", 64'(rr_done), 64'd4);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Move the pointer to 1, then reset during a stuck read.
        do_write(0, 31'h0001040, 32'h0BADF00D);
        exp_read(0, 31'h0001030, '0, 1'b0, 1'b0);
        set_req(0, 1'b1, 1'b0, 31'h0001030, '0);
        repeat (3) tick();
        check("t5_pre_rst_rdata", 64'(bus.rsp_rdata), 64'h12345678);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_req_done", 64'(bus.req_done), 64'd0);
        check("t5_rst_req_err", 64'(bus.req_err), 64'd0);
        check("t5_rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("t5_rst_cmd_en", 64'(bus.mc_cmd_en), 64'd0);
        check("t5_rst_wr_en", 64'(bus.mc_wr_en), 64'd0);
        check("t5_rst_rd_en", 64'(bus.mc_rd_en), 64'd0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        tick();
        rst = 1'b0;
        tick();
        exp_write(0, 31'h0001050, 32'h11110000);
        exp_write(1, 31'h0001058, 32'h22220000);
        set_req(0, 1'b1, 1'b1, 31'h0001050, 32'h11110000);
        set_req(1, 1'b1, 1'b1, 31'h0001058, 32'h22220000);
        rr_done = 0;
        guard   = 0;
        while (rr_done < 2 && guard < 40) begin
            tick();
            guard++;
            for (int r = 0; r < 2; r++) begin
                if (bus.req_done[r]) begin
                    rr_done++;
                    set_req(r, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        check("t5_post_rst_done_count", 64'(rr_done), 64'd2);
        tick();

`ifdef MC_RD_TIMEOUT_EN
        // Read that never sees data must abort with an error and zero data.
        exp_read(0, 31'h0001060, '0, 1'b1, 1'b1);
        bus.mc_rd_empty = 1'b1;
        set_req(0, 1'b1, 1'b0, 31'h0001060, '0);
        lat = 0;
        wait_done(0, 40, lat);
        check("t6_timeout_err", 64'(bus.req_err), 64'd1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        tick();
`endif

        repeat (3) tick();
        check("end_mig_queue_empty", 64'(mig_q.size()), 64'd0);
        check("end_done_queue_empty", 64'(done_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mc_port_arbiter.md
Name: mc_port_arbiter

Overview:
- Shares the single MIG user port (command, write-data FIFO and read-data FIFO) between NREQ requesters, e.g. the SPART test-address generator and the MMU.
- Round-robin selection; one transaction outstanding at a time.
- Sequences each write as data push, then command. Sequences each read as command, then FIFO pop.
- Returns completion or read data to the granted requester.

Parameters:
- NREQ, 2: number of requesters (2..4).
- ADDR_W, 31: byte address width.
- DATA_W, 32: data word width.
- RD_TIMEOUT, 255: read-wait cycles before abort (used only with MC_RD_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester request; held until req_done
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  flattened; requester i in slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  flattened write data
- req_done  out  NREQ  one-hot, 1-cycle completion pulse
- req_err  out  NREQ  one-hot error pulse, coincident with req_done
- rsp_rdata  out  DATA_W  read data; valid when req_done pulses for a read
- mc_cmd_en  out  1  command strobe
- mc_cmd_instr  out  3  3'b000 write, 3'b001 read
- mc_cmd_addr  out  ADDR_W  command address
- mc_cmd_full  in  1  command FIFO full
- mc_wr_en  out  1  write-data strobe
- mc_wr_data  out  DATA_W  write data
- mc_wr_full  in  1  write-data FIFO full
- mc_rd_en  out  1  read-data pop
- mc_rd_data  in  DATA_W  read data
- mc_rd_empty  in  1  read-data FIFO empty

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; all strobes, req_done, req_err and rsp_rdata are 0.
  - rr pointer = 0, so requester 0 has highest priority first.
  - rst asserted mid-transaction aborts it: no done pulse; MIG-side strobes drop immediately.
- IDLE:
  - If any req_valid is set, pick the first set bit at or after rr pointer (wrapping modulo NREQ).
  - Latch grant index, we, addr and wdata into internal registers.
  - Next state: WR_DATA if we, else RD_CMD.
  - Later changes on the request bus are ignored until done.
- WR_DATA: mc_wr_en=1 with latched data in every cycle where mc_wr_full=0; the push occurs that cycle, next state WR_CMD. Stall while full.
- WR_CMD: mc_cmd_en=1, instr 000, latched addr, when mc_cmd_full=0; next DONE. Stall while full.
- RD_CMD: as WR_CMD with instr 001; next RD_WAIT.
- RD_WAIT: when mc_rd_empty=0, assert mc_rd_en and capture mc_rd_data into rsp_rdata; next DONE.
- DONE:
  - req_done[grant]=1 for exactly one cycle; rsp_rdata holds until the next read completes.
  - rr pointer = (grant+1) mod NREQ; next IDLE.
- Strobes are registered-state decodes: high only in their state, and only when the matching full/empty permits.
- Minimum latency from req_valid to req_done: write 4 cycles (IDLE, WR_DATA, WR_CMD, DONE); read 4 cycles when the FIFO is already non-empty.
- Requester may deassert req_valid on the cycle after req_done. If still asserted, it re-competes next IDLE, but only after other pending requesters are served.
- Write address and data are passed through unaligned; alignment is the requester's responsibility.

Optional Feature:
- MC_RD_TIMEOUT_EN defined:
  - An 8-bit-min counter runs in RD_WAIT. After RD_TIMEOUT cycles with mc_rd_empty=1, go to DONE with req_err[grant]=1 and rsp_rdata=0.
  - A late-arriving word is not popped by this block.
- Undefined: no counter; RD_WAIT waits indefinitely; req_err is tied 0.

Decomposition:
- Package/header mc_arb_defs:
  - MC_INSTR_WR=3'b000, MC_INSTR_RD=3'b001.
  - State encodings IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, DONE (3 bits).
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: grant index, any_valid.
  - Instantiated once.

Test Plan:
- Single write, requester 0: addr 0x0001000, data 0xDEADBEEF, FIFOs never full -> mc_wr_en in cycle 2, mc_cmd_en (instr 000, addr 0x0001000) in cycle 3, req_done[0] in cycle 4.
- Write backpressure: mc_wr_full=1 for 5 cycles, then mc_cmd_full=1 for 3 cycles -> exactly one mc_wr_en and one mc_cmd_en, each on the first non-full cycle; done 8 cycles later than the unstalled case.
- Read: requester 1, addr 0x0001020; mc_rd_empty drops 6 cycles after the command with data 0x12345678 -> single mc_rd_en, rsp_rdata=0x12345678, req_done[1]=1.
- Round-robin: both requesters held valid continuously, writes to addresses 0x0001000..0x0001020 -> grants alternate 0,1,0,1; no requester served twice in a row.
- Reset mid-read: rst pulsed in RD_WAIT -> all outputs 0 immediately, no req_done; next request after reset is served by requester 0 first.
- With MC_RD_TIMEOUT_EN and RD_TIMEOUT=10: read with mc_rd_empty stuck at 1 -> req_done and req_err pulse together, rsp_rdata=0, and mc_rd_en never asserted.
